// File: rtl/exu_cal_pkg.sv
// exu_cal_pkg: shared definitions for the execute-unit calculation centre.
//   - layout of the packed calculation bundle (op one-hot bits + two 33-bit operands)
//   - FSM state encodings of the iterative shifter
//   - shift-mode encodings handed from exu_cal to cal_shifter
// Optional feature macro used by the importing files: CIRNO_CAL_BARREL_EN.
package exu_cal_pkg;

    // Operand fields: 33-bit extended operands, bit 32 is the extension bit.
    localparam int unsigned CAL_OPN_W    = 33;
    localparam int unsigned CAL_OPN2_LSB = 0;
    localparam int unsigned CAL_OPN2_MSB = 32;
    localparam int unsigned CAL_OPN1_LSB = 33;
    localparam int unsigned CAL_OPN1_MSB = 65;

    // Op one-hot bit indices, in bundle order.
    localparam int unsigned CAL_ADD = 66;
    localparam int unsigned CAL_SUB = 67;
    localparam int unsigned CAL_SLL = 68;
    localparam int unsigned CAL_SRL = 69;
    localparam int unsigned CAL_SRA = 70;
    localparam int unsigned CAL_XOR = 71;
    localparam int unsigned CAL_CMP = 72;

    localparam int unsigned CAL_OPB_SIZE = 73;

    typedef enum logic [1:0] {
        CAL_ST_IDLE  = 2'd0,
        CAL_ST_SHIFT = 2'd1,
        CAL_ST_DONE  = 2'd2
    } cal_state_e;

    localparam logic [1:0] CAL_SH_SLL = 2'd0;
    localparam logic [1:0] CAL_SH_SRL = 2'd1;
    localparam logic [1:0] CAL_SH_SRA = 2'd2;

endpackage

// File: rtl/cal_shifter.sv
// cal_shifter: iterative shift datapath for exu_cal.
//   Holds the shift register and the remaining-amount counter; each step shifts by
//   min(SHIFT_STEP, rem) and decrements rem by the same amount.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        capture din/shamt/mode (start of a shift)
//   step        perform one shift step
//   clr         abandon the current operation (zero sreg and rem)
//   mode        CAL_SH_SLL / CAL_SH_SRL / CAL_SH_SRA
//   din         value to shift
//   shamt       total shift amount
//   sreg        current shift register contents
//   last        the next step finishes the shift (rem <= SHIFT_STEP)
module cal_shifter
    import exu_cal_pkg::*;
#(
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        clr,
    input  logic [1:0]  mode,
    input  logic [31:0] din,
    input  logic [4:0]  shamt,
    output logic [31:0] sreg,
    output logic        last
);

    localparam logic [4:0] STEP_AMT = 5'(SHIFT_STEP);

    logic [31:0] sreg_q;
    logic [31:0] sreg_nxt;
    logic [4:0]  rem_q;
    logic [4:0]  k;
    logic [1:0]  mode_q;

    assign k    = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
    assign last = (rem_q <= STEP_AMT);
    assign sreg = sreg_q;

    always_comb begin
        sreg_nxt = sreg_q;
        unique case (mode_q)
            CAL_SH_SLL: sreg_nxt = sreg_q << k;
            CAL_SH_SRL: sreg_nxt = sreg_q >> k;
            CAL_SH_SRA: sreg_nxt = 32'($signed(sreg_q) >>> k);
            default:    sreg_nxt = sreg_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            rem_q  <= '0;
            mode_q <= CAL_SH_SLL;
        end else if (clr) begin
            sreg_q <= '0;
            rem_q  <= '0;
        end else if (load) begin
            sreg_q <= din;
            rem_q  <= shamt;
            mode_q <= mode;
        end else if (step) begin
            sreg_q <= sreg_nxt;
            rem_q  <= rem_q - k;
        end
    end

endmodule

// File: rtl/exu_cal.sv
// exu_cal: shared calculation centre of the execute unit.
//   ADD/SUB/XOR/CMP (and zero-amount shifts) complete in the request cycle.
//   SLL/SRL/SRA with a non-zero amount run on an iterative shifter FSM
//   (IDLE -> SHIFT -> DONE) and back-pressure the ALU meanwhile.
//   Define CIRNO_CAL_BARREL_EN to replace the FSM with a combinational barrel shifter.
// Ports:
//   clk            core clock
//   rst_n          asynchronous active-low reset
//   hs_al4cal_val  request valid, held with a stable bundle until rdy
//   hs_cal4al_rdy  result valid / request consumed (combinational)
//   i_cal_opb      packed bundle: op one-hot, OPN1[32:0], OPN2[32:0]
//   o_cal_res      result, 0 whenever rdy is low
//   o_cal_busy     shifter FSM not idle
module exu_cal
    import exu_cal_pkg::*;
#(
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hs_al4cal_val,
    output logic                    hs_cal4al_rdy,
    input  logic [CAL_OPB_SIZE-1:0] i_cal_opb,
    output logic [31:0]             o_cal_res,
    output logic                    o_cal_busy
);

    logic [32:0] opn1;
    logic [32:0] opn2;
    logic        op_add, op_sub, op_sll, op_srl, op_sra, op_xor, op_cmp;
    logic        is_shift;
    logic [4:0]  shamt;
    logic [32:0] diff;
    logic [31:0] shift_res;
    logic [31:0] fast_res;

    assign opn1     = i_cal_opb[CAL_OPN1_MSB:CAL_OPN1_LSB];
    assign opn2     = i_cal_opb[CAL_OPN2_MSB:CAL_OPN2_LSB];
    assign op_add   = i_cal_opb[CAL_ADD];
    assign op_sub   = i_cal_opb[CAL_SUB];
    assign op_sll   = i_cal_opb[CAL_SLL];
    assign op_srl   = i_cal_opb[CAL_SRL];
    assign op_sra   = i_cal_opb[CAL_SRA];
    assign op_xor   = i_cal_opb[CAL_XOR];
    assign op_cmp   = i_cal_opb[CAL_CMP];
    assign is_shift = op_sll | op_srl | op_sra;
    assign shamt    = opn2[4:0];

    // Operands arrive sign- or zero-extended, so the 33-bit borrow is the compare result.
    assign diff = opn1 - opn2;

    always_comb begin
        fast_res = '0;
        unique case (1'b1)
            op_add:  fast_res = opn1[31:0] + opn2[31:0];
            op_sub:  fast_res = diff[31:0];
            op_xor:  fast_res = opn1[31:0] ^ opn2[31:0];
            op_cmp:  fast_res = {31'b0, diff[32]};
            default: fast_res = shift_res;
        endcase
    end

`ifdef CIRNO_CAL_BARREL_EN

    always_comb begin
        shift_res = opn1[31:0];
        if (op_sll) begin
            shift_res = opn1[31:0] << shamt;
        end else if (op_srl) begin
            shift_res = opn1[31:0] >> shamt;
        end else if (op_sra) begin
            shift_res = 32'($signed(opn1[31:0]) >>> shamt);
        end
    end

    assign hs_cal4al_rdy = rst_n & hs_al4cal_val;
    assign o_cal_res     = hs_cal4al_rdy ? fast_res : '0;
    assign o_cal_busy    = 1'b0;

`else

    cal_state_e  state;
    logic        start;
    logic        fast;
    logic        sh_step;
    logic        sh_clr;
    logic        sh_last;
    logic [1:0]  sh_mode;
    logic [31:0] sreg;

    // Only a zero-amount shift reaches the single-cycle path; it returns OPN1 unchanged.
    assign shift_res = opn1[31:0];

    assign fast    = ~is_shift | (shamt == 5'd0);
    assign start   = (state == CAL_ST_IDLE) & hs_al4cal_val & ~fast;
    assign sh_step = (state == CAL_ST_SHIFT) & hs_al4cal_val;
    // Dropping val mid-operation is a flush: the partial result is thrown away.
    assign sh_clr  = (state != CAL_ST_IDLE) & ~hs_al4cal_val;
    assign sh_mode = op_sra ? CAL_SH_SRA : (op_srl ? CAL_SH_SRL : CAL_SH_SLL);

    cal_shifter #(
        .SHIFT_STEP (SHIFT_STEP)
    ) u_cal_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start),
        .step  (sh_step),
        .clr   (sh_clr),
        .mode  (sh_mode),
        .din   (opn1[31:0]),
        .shamt (shamt),
        .sreg  (sreg),
        .last  (sh_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CAL_ST_IDLE;
        end else begin
            unique case (state)
                CAL_ST_IDLE: begin
                    if (start) begin
                        state <= CAL_ST_SHIFT;
                    end
                end
                CAL_ST_SHIFT: begin
                    if (!hs_al4cal_val) begin
                        state <= CAL_ST_IDLE;
                    end else if (sh_last) begin
                        state <= CAL_ST_DONE;
                    end
                end
                // Either the handshake completes or val dropped: both return to IDLE.
                CAL_ST_DONE: state <= CAL_ST_IDLE;
                default:     state <= CAL_ST_IDLE;
            endcase
        end
    end

    assign hs_cal4al_rdy = rst_n & hs_al4cal_val &
                           (((state == CAL_ST_IDLE) & fast) | (state == CAL_ST_DONE));
    assign o_cal_res     = !hs_cal4al_rdy ? '0 : ((state == CAL_ST_DONE) ? sreg : fast_res);
    assign o_cal_busy    = (state != CAL_ST_IDLE);

`endif

endmodule

// File: tb/tb_exu_cal.sv
// tb_exu_cal: self-checking bench for exu_cal.
//   Two instances (SHIFT_STEP=1 and SHIFT_STEP=4) share clock and reset; directed steps
//   followed by random requests checked against an arithmetic reference model.
module tb_exu_cal;
    import exu_cal_pkg::*;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_SLL = 2;
    localparam int OP_SRL = 3;
    localparam int OP_SRA = 4;
    localparam int OP_XOR = 5;
    localparam int OP_CMP = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic                    val1 = 1'b0, val4 = 1'b0;
    logic [CAL_OPB_SIZE-1:0] opb1 = '0, opb4 = '0;
    logic                    rdy1, rdy4, busy1, busy4;
    logic [31:0]             res1, res4;
    bit                      sel = 1'b0;

    logic        rdy_s, busy_s;
    logic [31:0] res_s;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exu_cal #(
        .SHIFT_STEP (1)
    ) u_dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .hs_al4cal_val (val1),
        .hs_cal4al_rdy (rdy1),
        .i_cal_opb     (opb1),
        .o_cal_res     (res1),
        .o_cal_busy    (busy1)
    );

    exu_cal #(
        .SHIFT_STEP (4)
    ) u_dut4 (
        .clk           (clk),
        .rst_n         (rst_n),
        .hs_al4cal_val (val4),
        .hs_cal4al_rdy (rdy4),
        .i_cal_opb     (opb4),
        .o_cal_res     (res4),
        .o_cal_busy    (busy4)
    );

    assign rdy_s  = sel ? rdy4 : rdy1;
    assign busy_s = sel ? busy4 : busy1;
    assign res_s  = sel ? res4 : res1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [CAL_OPB_SIZE-1:0] pack(input int op, input logic [32:0] a,
                                                     input logic [32:0] b);
        logic [CAL_OPB_SIZE-1:0] p;
        p = '0;
        p[CAL_ADD + op] = 1'b1;
        p[CAL_OPN1_MSB:CAL_OPN1_LSB] = a;
        p[CAL_OPN2_MSB:CAL_OPN2_LSB] = b;
        return p;
    endfunction

    // Reference model: results from plain arithmetic on the operand values.
    function automatic logic [31:0] model_res(input int op, input logic [32:0] a,
                                              input logic [32:0] b);
        logic [31:0] x, y, r;
        int sh;
        x  = a[31:0];
        y  = b[31:0];
        sh = int'(b[4:0]);
        case (op)
            OP_ADD: r = x + y;
            OP_SUB: r = x - y;
            OP_XOR: r = x ^ y;
            OP_CMP: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLL: r = x << sh;
            OP_SRL: r = x >> sh;
            OP_SRA: begin
                r = x >> sh;
                if (x[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Cycles from first val to rdy, counting both ends.
    function automatic int model_lat(input bit s, input int op, input logic [32:0] b);
        int st, sh;
        st = s ? 4 : 1;
        sh = int'(b[4:0]);
        if ((op == OP_SLL || op == OP_SRL || op == OP_SRA) && sh != 0)
            return 2 + (sh + st - 1) / st;
        return 1;
    endfunction

    task automatic drive(input bit s, input logic v, input logic [CAL_OPB_SIZE-1:0] o);
        if (s) begin
            val4 = v;
            opb4 = o;
        end else begin
            val1 = v;
            opb1 = o;
        end
    endtask

    task automatic run_op(input bit s, input int op, input logic [32:0] a,
                          input logic [32:0] b, input string tag);
        logic [31:0] er;
        int el, cyc;
        bit got;
        er  = model_res(op, a, b);
        el  = model_lat(s, op, b);
        sel = s;
        @(posedge clk);
        #1;
        drive(s, 1'b1, pack(op, a, b));
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk({tag, "_busy1"}, 32'(busy_s), 32'd0);
            if (cyc == 2) chk({tag, "_busy2"}, 32'(busy_s), (el > 2) ? 32'd1 : 32'd0);
            if (rdy_s) begin
                got = 1'b1;
                chk({tag, "_res"}, res_s, er);
            end else begin
                chk({tag, "_res_idle"}, res_s, 32'd0);
            end
        end
        chk({tag, "_rdy_seen"}, 32'(got), 32'd1);
        chk({tag, "_lat"}, 32'(cyc), 32'(el));
        @(posedge clk);
        #1;
        drive(s, 1'b0, '0);
        @(negedge clk);
        chk({tag, "_busy_end"}, 32'(busy_s), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [32:0] a, b;
        logic [31:0] ra, rb;
        int op;
        bit s;

        // Reset state.
        #12;
        chk("reset_rdy", 32'(rdy1), 32'd0);
        chk("reset_busy", 32'(busy1), 32'd0);
        chk("reset_res", res1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        run_op(0, OP_ADD, 33'h1_FFFF_FFFF, 33'h0_0000_0001, "add_wrap");
        run_op(0, OP_CMP, 33'h1_FFFF_FFFF, 33'h0_0000_0001, "cmp_signed");
        run_op(0, OP_CMP, 33'h0_FFFF_FFFF, 33'h0_0000_0001, "cmp_unsigned");
        run_op(0, OP_SLL, 33'h0_0000_0001, 33'h0_0000_0005, "sll5_step1");
        run_op(1, OP_SLL, 33'h0_0000_0001, 33'h0_0000_0005, "sll5_step4");
        run_op(0, OP_SRA, 33'h0_8000_0000, 33'h0_0000_001F, "sra31");
        run_op(0, OP_SRL, 33'h0_8000_0000, 33'h0_0000_001F, "srl31");
        run_op(1, OP_SRA, 33'h0_8000_0000, 33'h0_0000_001F, "sra31_step4");
        run_op(0, OP_SUB, 33'h0_0000_0003, 33'h0_0000_0005, "sub_neg");
        run_op(0, OP_XOR, 33'h0_F0F0_1234, 33'h0_0FF0_FFFF, "xor");

        // Flush: drop val in the third SHIFT cycle, then ADD right away.
        sel = 1'b0;
        @(posedge clk);
        #1;
        drive(0, 1'b1, pack(OP_SRL, 33'h0_DEAD_BEEF, 33'h0_0000_0010));
        repeat (3) @(posedge clk);
        #1;
        drive(0, 1'b0, '0);
        @(negedge clk);
        chk("flush_busy_shift", 32'(busy1), 32'd1);
        chk("flush_rdy_shift", 32'(rdy1), 32'd0);
        @(posedge clk);
        #1;
        drive(0, 1'b1, pack(OP_ADD, 33'h0_1234_5678, 33'h0_1111_1111));
        @(negedge clk);
        chk("flush_idle_busy", 32'(busy1), 32'd0);
        chk("flush_add_rdy", 32'(rdy1), 32'd1);
        chk("flush_add_res", res1, 32'h2345_6789);
        @(posedge clk);
        #1;
        drive(0, 1'b0, '0);

        // Asynchronous reset in the middle of a shift.
        @(posedge clk);
        #1;
        drive(0, 1'b1, pack(OP_SLL, 33'h0_0000_0003, 33'h0_0000_0014));
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset_busy", 32'(busy1), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_busy", 32'(busy1), 32'd0);
        chk("mid_reset_rdy", 32'(rdy1), 32'd0);
        chk("mid_reset_res", res1, 32'd0);
        drive(0, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, OP_SLL, 33'h0_CAFE_F00D, 33'h0_0000_0000, "sll_zero");

        // Random requests against the model.
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 6));
            s  = (i % 4 == 3);
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                a = {ra[31], ra};
                b = {rb[31], rb};
            end else begin
                a = {1'b0, ra};
                b = {1'b0, rb};
            end
            if ($urandom_range(0, 4) == 0) b[4:0] = 5'd0;
            run_op(s, op, a, b, $sformatf("rand%0d_op%0d", i, op));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
